// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall/flush controller for the 5-stage core.
// Merges load-use (ID), mult/div (EX), data-SRAM wait (MEM) and exception
// flush requests into the per-stage stall bus and a flush strobe. A small
// FSM tracks the in-flight mult/div operation, guarded by a watchdog.
//
// Optional feature: define STALL_PERF_CNT_EN to build saturating
// performance counters for stalled cycles and flushes. When the macro is
// undefined no counter registers exist and both perf ports read 0.
//
// Stall bus bit map: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM,
// bit4 MEM/WB, bit5 WB. A set bit holds that stage register.
//
// Mult/div handshake: md_start is a single-cycle pulse from EX that is
// accepted only in IDLE (a pulse in any other state is a protocol error and
// is dropped). md_ready is a single-cycle pulse from the unit that is
// consumed only in MD_WAIT (ignored in IDLE). md_abort tells the unit to
// drop its operation; it pulses on an exception flush that catches a live
// or just-issued operation, and on a watchdog expiry.

module pipe_stall_ctrl #(
    parameter int STALL_W    = 6,
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id,
    input  logic               md_start,
    input  logic               md_ready,
    input  logic               mem_stallreq,
    input  logic               excp_flush,
    input  logic [31:0]        excp_new_pc,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic               md_busy,
    output logic               md_abort,
    output logic               md_timeout,
    output logic [CNT_W-1:0]   perf_stall_cnt,
    output logic [CNT_W-1:0]   perf_flush_cnt,
    output logic [1:0]         o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MD_WAIT = 2'd1,
        MD_DONE = 2'd2
    } state_e;

    // Hold patterns: MEM wait freezes everything up to MEM/WB, a mult/div
    // freezes up to EX/MEM, a load-use bubble freezes up to ID/EX.
    localparam logic [STALL_W-1:0] STALL_NONE = '0;
    localparam logic [STALL_W-1:0] STALL_MEM  = STALL_W'(5'b11111);
    localparam logic [STALL_W-1:0] STALL_MD   = STALL_W'(4'b1111);
    localparam logic [STALL_W-1:0] STALL_ID   = STALL_W'(3'b111);

    localparam int                TMO_W    = $clog2(MD_TIMEOUT) + 1;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(MD_TIMEOUT - 1);

    state_e             r_state;
    state_e             w_next;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_md_busy;
    logic               w_tmo_hit;
    logic [STALL_W-1:0] w_stall;
    logic               w_flush;
    logic [31:0]        w_new_pc;
    logic               w_abort;
    logic               w_timeout;

    // Watchdog expires on the last allowed MD_WAIT cycle without a result.
    assign w_tmo_hit = (r_state == MD_WAIT) && !md_ready && (r_tmo_cnt == TMO_LAST);

    // State register; reset returns straight to IDLE with no abort pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; an exception flush overrides every transition.
    always_comb begin
        w_next = r_state;
        if (excp_flush) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (md_start) begin
                        w_next = MD_WAIT;
                    end
                end
                MD_WAIT: begin
                    if (md_ready) begin
                        // Park the result in MD_DONE while MEM is still stalled.
                        w_next = mem_stallreq ? MD_DONE : IDLE;
                    end else if (w_tmo_hit) begin
                        w_next = IDLE;
                    end
                end
                MD_DONE: begin
                    if (!mem_stallreq) begin
                        w_next = IDLE;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Output logic: priority-ordered stall/flush selection, zero latency.
    always_comb begin
        w_stall   = STALL_NONE;
        w_flush   = 1'b0;
        w_new_pc  = 32'h0;
        w_abort   = 1'b0;
        w_timeout = 1'b0;
        if (excp_flush) begin
            w_flush  = 1'b1;
            w_new_pc = excp_new_pc;
            w_abort  = (r_state != IDLE) || md_start;
        end else begin
            if (mem_stallreq) begin
                w_stall = STALL_MEM;
            end else if (r_state == IDLE && md_start) begin
                w_stall = STALL_MD;
            end else if (r_state == MD_WAIT && !md_ready) begin
                w_stall = STALL_MD;
            end else if (r_state == MD_WAIT || r_state == MD_DONE) begin
                w_stall = STALL_NONE;
            end else if (stallreq_id) begin
                w_stall = STALL_ID;
            end
            // The watchdog still holds the pipe this cycle; release follows.
            if (w_tmo_hit) begin
                w_timeout = 1'b1;
                w_abort   = 1'b1;
            end
        end
    end

    // Combinational outputs are forced quiet while reset is asserted.
    assign stall      = rst ? w_stall   : STALL_NONE;
    assign flush      = rst ? w_flush   : 1'b0;
    assign new_pc     = rst ? w_new_pc  : 32'h0;
    assign md_abort   = rst ? w_abort   : 1'b0;
    assign md_timeout = rst ? w_timeout : 1'b0;

    // Watchdog counter: cleared on entry to MD_WAIT, counts while staying.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state != MD_WAIT) begin
            if (w_next == MD_WAIT) begin
                r_tmo_cnt <= '0;
            end
        end else if (w_next == MD_WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    // Busy flag registered alongside the state so it is glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_md_busy <= 1'b0;
        end else begin
            r_md_busy <= (w_next != IDLE);
        end
    end

    assign md_busy     = r_md_busy;
    assign o_dbg_state = r_state;

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_stall;
    logic [CNT_W-1:0] r_perf_flush;

    // Saturating count of cycles with any stage held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_stall <= '0;
        end else if ((|stall) && (r_perf_stall != {CNT_W{1'b1}})) begin
            r_perf_stall <= r_perf_stall + CNT_W'(1);
        end
    end

    // Saturating count of flush cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_flush <= '0;
        end else if (flush && (r_perf_flush != {CNT_W{1'b1}})) begin
            r_perf_flush <= r_perf_flush + CNT_W'(1);
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: a per-cycle vector table for the
// priority/transition behaviour, plus hand-written sequences for the
// watchdog, asynchronous reset and the performance counters.

module tb_pipe_stall_ctrl;

    localparam int STALL_W    = 6;
    localparam int MD_TIMEOUT = 64;
    localparam int CNT_W      = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic               clk;
    logic               rst;
    logic               stallreq_id;
    logic               md_start;
    logic               md_ready;
    logic               mem_stallreq;
    logic               excp_flush;
    logic [31:0]        excp_new_pc;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [31:0]        new_pc;
    logic               md_busy;
    logic               md_abort;
    logic               md_timeout;
    logic [CNT_W-1:0]   perf_stall_cnt;
    logic [CNT_W-1:0]   perf_flush_cnt;
    logic [1:0]         o_dbg_state;

    int tests_run;
    int tests_failed;

    pipe_stall_ctrl #(
        .STALL_W    (STALL_W),
        .MD_TIMEOUT (MD_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_id    (stallreq_id),
        .md_start       (md_start),
        .md_ready       (md_ready),
        .mem_stallreq   (mem_stallreq),
        .excp_flush     (excp_flush),
        .excp_new_pc    (excp_new_pc),
        .stall          (stall),
        .flush          (flush),
        .new_pc         (new_pc),
        .md_busy        (md_busy),
        .md_abort       (md_abort),
        .md_timeout     (md_timeout),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .o_dbg_state    (o_dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sid;
        logic        mds;
        logic        mdr;
        logic        mem;
        logic        exf;
        logic [31:0] epc;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        logic        e_busy;
        logic        e_abort;
        logic        e_tmo;
        logic [1:0]  e_state;
    } vec_t;

    localparam int NVEC = 23;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic sid, input logic mds, input logic mdr,
                                input logic mem, input logic exf, input logic [31:0] epc,
                                input logic [5:0] e_stall, input logic e_flush,
                                input logic [31:0] e_pc, input logic e_busy,
                                input logic e_abort, input logic [1:0] e_state);
        vec_t v;
        v.sid = sid; v.mds = mds; v.mdr = mdr; v.mem = mem; v.exf = exf; v.epc = epc;
        v.e_stall = e_stall; v.e_flush = e_flush; v.e_pc = e_pc; v.e_busy = e_busy;
        v.e_abort = e_abort; v.e_tmo = 1'b0; v.e_state = e_state;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sid, input logic mds, input logic mdr,
                         input logic mem, input logic exf, input logic [31:0] epc);
        stallreq_id  = sid;
        md_start     = mds;
        md_ready     = mdr;
        mem_stallreq = mem;
        excp_flush   = exf;
        excp_new_pc  = epc;
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        drive(0, 0, 0, 0, 0, 32'h0);

        //           sid mds mdr mem exf epc           stall      flush pc           busy abort state
        tbl[0]  = mk(0,  0,  0,  0,  0,  32'h0,        6'b000000, 0, 32'h0,        0, 0, S_IDLE);
        tbl[1]  = mk(1,  0,  0,  0,  0,  32'hDEADBEEF, 6'b000111, 0, 32'h0,        0, 0, S_IDLE);
        tbl[2]  = mk(0,  1,  0,  0,  0,  32'h0,        6'b001111, 0, 32'h0,        0, 0, S_IDLE);
        tbl[3]  = mk(0,  0,  0,  0,  0,  32'h0,        6'b001111, 0, 32'h0,        1, 0, S_WAIT);
        tbl[4]  = mk(1,  0,  0,  0,  0,  32'h0,        6'b001111, 0, 32'h0,        1, 0, S_WAIT);
        tbl[5]  = mk(0,  0,  1,  0,  0,  32'h0,        6'b000000, 0, 32'h0,        1, 0, S_WAIT);
        tbl[6]  = mk(0,  0,  0,  0,  0,  32'h0,        6'b000000, 0, 32'h0,        0, 0, S_IDLE);
        tbl[7]  = mk(0,  0,  1,  0,  0,  32'h0,        6'b000000, 0, 32'h0,        0, 0, S_IDLE);
        tbl[8]  = mk(0,  1,  0,  1,  0,  32'h0,        6'b011111, 0, 32'h0,        0, 0, S_IDLE);
        tbl[9]  = mk(0,  0,  0,  1,  0,  32'h0,        6'b011111, 0, 32'h0,        1, 0, S_WAIT);
        tbl[10] = mk(0,  0,  1,  1,  0,  32'h0,        6'b011111, 0, 32'h0,        1, 0, S_WAIT);
        tbl[11] = mk(0,  0,  0,  1,  0,  32'h0,        6'b011111, 0, 32'h0,        1, 0, S_DONE);
        tbl[12] = mk(0,  1,  0,  0,  0,  32'h0,        6'b000000, 0, 32'h0,        1, 0, S_DONE);
        tbl[13] = mk(0,  0,  0,  0,  0,  32'h0,        6'b000000, 0, 32'h0,        0, 0, S_IDLE);
        tbl[14] = mk(0,  1,  0,  0,  0,  32'h0,        6'b001111, 0, 32'h0,        0, 0, S_IDLE);
        tbl[15] = mk(1,  0,  0,  0,  1,  32'hBFC00380, 6'b000000, 1, 32'hBFC00380, 1, 1, S_WAIT);
        tbl[16] = mk(0,  0,  0,  0,  0,  32'h0,        6'b000000, 0, 32'h0,        0, 0, S_IDLE);
        tbl[17] = mk(0,  0,  0,  0,  1,  32'h80000000, 6'b000000, 1, 32'h80000000, 0, 0, S_IDLE);
        tbl[18] = mk(0,  1,  0,  1,  1,  32'h80000180, 6'b000000, 1, 32'h80000180, 0, 1, S_IDLE);
        tbl[19] = mk(0,  0,  0,  0,  0,  32'h0,        6'b000000, 0, 32'h0,        0, 0, S_IDLE);
        tbl[20] = mk(0,  1,  0,  0,  0,  32'h0,        6'b001111, 0, 32'h0,        0, 0, S_IDLE);
        tbl[21] = mk(0,  0,  1,  0,  1,  32'h12345678, 6'b000000, 1, 32'h12345678, 1, 1, S_WAIT);
        tbl[22] = mk(0,  0,  0,  0,  0,  32'h0,        6'b000000, 0, 32'h0,        0, 0, S_IDLE);

        // Reset state
        #12;
        chk("rst_stall",  32'(stall), 32'h0);
        chk("rst_busy",   32'(md_busy), 32'h0);
        chk("rst_state",  32'(o_dbg_state), 32'(S_IDLE));
        chk("rst_pstall", perf_stall_cnt, 32'h0);
        chk("rst_pflush", perf_flush_cnt, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();

        // Table-driven per-cycle vectors
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].sid, tbl[i].mds, tbl[i].mdr, tbl[i].mem, tbl[i].exf, tbl[i].epc);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i),   32'(stall),       32'(tbl[i].e_stall));
            chk($sformatf("v%0d_flush", i),   32'(flush),       32'(tbl[i].e_flush));
            chk($sformatf("v%0d_new_pc", i),  new_pc,           tbl[i].e_pc);
            chk($sformatf("v%0d_busy", i),    32'(md_busy),     32'(tbl[i].e_busy));
            chk($sformatf("v%0d_abort", i),   32'(md_abort),    32'(tbl[i].e_abort));
            chk($sformatf("v%0d_timeout", i), 32'(md_timeout),  32'(tbl[i].e_tmo));
            chk($sformatf("v%0d_state", i),   32'(o_dbg_state), 32'(tbl[i].e_state));
            next_cycle();
        end

        // Watchdog: issue with no result, expect expiry on the 64th MD_WAIT cycle
        drive(0, 1, 0, 0, 0, 32'h0);
        @(negedge clk);
        chk("tmo_issue_stall", 32'(stall), 32'h0F);
        next_cycle();
        drive(0, 0, 0, 0, 0, 32'h0);
        for (int k = 1; k <= MD_TIMEOUT; k++) begin
            @(negedge clk);
            chk($sformatf("tmo_c%0d_stall", k),   32'(stall),      32'h0F);
            chk($sformatf("tmo_c%0d_timeout", k), 32'(md_timeout), (k == MD_TIMEOUT) ? 32'h1 : 32'h0);
            chk($sformatf("tmo_c%0d_abort", k),   32'(md_abort),   (k == MD_TIMEOUT) ? 32'h1 : 32'h0);
            next_cycle();
        end
        @(negedge clk);
        chk("tmo_after_stall",   32'(stall),       32'h0);
        chk("tmo_after_busy",    32'(md_busy),     32'h0);
        chk("tmo_after_state",   32'(o_dbg_state), 32'(S_IDLE));
        chk("tmo_after_timeout", 32'(md_timeout),  32'h0);
        next_cycle();

        // Asynchronous reset mid-operation, with a flush also requested
        drive(0, 1, 0, 0, 0, 32'h0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 32'h0);
        #1;
        chk("arst_pre_state", 32'(o_dbg_state), 32'(S_WAIT));
        drive(0, 0, 0, 0, 1, 32'hBFC00380);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_state",  32'(o_dbg_state), 32'(S_IDLE));
        chk("arst_busy",   32'(md_busy),     32'h0);
        chk("arst_stall",  32'(stall),       32'h0);
        chk("arst_flush",  32'(flush),       32'h0);
        chk("arst_new_pc", new_pc,           32'h0);
        chk("arst_abort",  32'(md_abort),    32'h0);
        chk("arst_pstall", perf_stall_cnt,   32'h0);
        chk("arst_pflush", perf_flush_cnt,   32'h0);
        drive(0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();

        // Performance counters: three load-use cycles then one flush
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 0, 32'h0);
            next_cycle();
        end
        drive(0, 0, 0, 0, 1, 32'h00000400);
        next_cycle();
        drive(0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
`ifdef STALL_PERF_CNT_EN
        chk("perf_stall_cnt", perf_stall_cnt, 32'd3);
        chk("perf_flush_cnt", perf_flush_cnt, 32'd1);
`else
        chk("perf_stall_cnt", perf_stall_cnt, 32'd0);
        chk("perf_flush_cnt", perf_flush_cnt, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
